axi_sram_slave: RTL and testbench

//   AXI3 slave memory model: the responder end of the CPU's AXI master port.

---
 rtl/axi_sram_if.sv | 74 +++++++
 rtl/axi_sram_slave.sv | 215 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI3 bus bundle between the CPU-side master and the SRAM slave.
// Sideband fields the slave ignores are still carried so the bundle is complete.
interface axi_sram_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 burst slave backed by a word array; independent read and write
// channels, one outstanding burst each.
module axi_sram_slave #(
    parameter int MEM_AW       = 14,
    parameter int READ_LATENCY = 1
) (
    input logic       clk,
    input logic       reset,
    axi_sram_if.slave bus
);
    localparam int WLW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WLW-1:0] WAIT_INIT = WLW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem_q [2**MEM_AW];

    function automatic logic [31:0] next_addr(
        input logic [31:0] a,
        input logic [2:0]  sz,
        input logic [1:0]  bt
    );
        return (bt == 2'b00) ? a : a + (32'd1 << sz);
    endfunction

    function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
        return a[MEM_AW+1:2];
    endfunction

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic [WLW-1:0] r_wait_q, r_wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] r_step;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic        w_err_q, w_err_d;
    logic        mem_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_wait_q  <= r_wait_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_wait_d  = r_wait_q;
        rdata_d   = rdata_q;
        r_step    = next_addr(r_addr_q, r_size_q, r_burst_q);
        unique case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_id_d    = bus.arid;
                    r_addr_d  = bus.araddr;
                    r_len_d   = bus.arlen;
                    r_size_d  = bus.arsize;
                    r_burst_d = bus.arburst;
                    r_cnt_d   = '0;
                    r_wait_d  = WAIT_INIT;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_wait_q == '0) begin
                    rdata_d   = mem_q[widx(r_addr_q)];
                    r_state_d = R_BURST;
                end else begin
                    r_wait_d = r_wait_q - WLW'(1);
                end
            end
            R_BURST: begin
                if (bus.rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_step;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        rdata_d  = mem_q[widx(r_step)];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_BURST);
    assign bus.rlast   = bus.rvalid && (r_cnt_q == r_len_q);
    assign bus.rid     = r_id_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // The beat count, not wlast, closes the burst; a wlast mismatch only flags SLVERR.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_id_d    = bus.awid;
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_size_d  = bus.awsize;
                    w_burst_d = bus.awburst;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we  = 1'b1;
                    w_err_d = w_err_q |
                              (bus.wlast != (w_cnt_q == w_len_q));
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = w_id_q;
    assign bus.bresp   = (bus.bvalid && w_err_q) ? 2'b10 : 2'b00;

    // Memory is deliberately not reset; contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b])
                    mem_q[widx(w_addr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave; expected R/B responses are queued
// at issue time and checked by an independent monitor.
module tb_axi_sram_slave;
    localparam int RL = 1;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  id;
        logic        last;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic tog = 1'b0;
    logic rhold = 1'b0;

    axi_sram_if bus();

    axi_sram_slave #(.MEM_AW(14), .READ_LATENCY(RL)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [3:0] id,
                         input logic last);
        rq.push_back({d, id, last});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.rready = tog ? ~bus.rready : ~rhold;
        end
    end

    initial begin : monitor
        logic stall_prev;
        logic [31:0] prev_d;
        logic prev_last;
        rexp_t re;
        bexp_t be;
        stall_prev = 1'b0;
        prev_d = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (bus.rvalid && stall_prev) begin
                    chk("r_stable_data", bus.rdata, prev_d);
                    chk("r_stable_last", bus.rlast, prev_last);
                end
                if (bus.rvalid && bus.rready) begin
                    if (rq.size() == 0) begin
                        chk("r_unexpected", 1, 0);
                    end else begin
                        re = rq.pop_front();
                        chk("rdata", bus.rdata, re.d);
                        chk("rid", bus.rid, re.id);
                        chk("rlast", bus.rlast, re.last);
                        chk("rresp", bus.rresp, 0);
                    end
                end
                stall_prev = bus.rvalid && !bus.rready;
                prev_d = bus.rdata;
                prev_last = bus.rlast;
                if (bus.bvalid && bus.bready) begin
                    if (bq.size() == 0) begin
                        chk("b_unexpected", 1, 0);
                    end else begin
                        be = bq.pop_front();
                        chk("bid", bus.bid, be.id);
                        chk("bresp", bus.bresp, be.resp);
                    end
                end
            end
        end
    end

    task automatic do_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
        int n;
        bit ok;
        bus.arid = id;
        bus.araddr = a;
        bus.arlen = len;
        bus.arsize = 3'd2;
        bus.arburst = bt;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ar_timeout", 0, 1);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.rvalid) break;
        end
        chk("r_latency", n, RL);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
        bit ok;
        bus.awid = id;
        bus.awaddr = a;
        bus.awlen = len;
        bus.awsize = 3'd2;
        bus.awburst = bt;
        bus.awvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.awready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("aw_timeout", 0, 1);
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input int n, input int lastidx, input bit chkb);
        bit ok;
        for (int i = 0; i < n; i++) begin
            bus.wdata = wd[i];
            bus.wstrb = ws[i];
            bus.wlast = (i == lastidx);
            bus.wvalid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (bus.wready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("w_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        if (chkb) begin
            @(negedge clk);
            chk("bvalid_after_last", bus.bvalid, 1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (rq.size() == 0 && bq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_r", rq.size(), 0);
        chk("drain_b", bq.size(), 0);
        rq.delete();
        bq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        wd[0] = d;
        ws[0] = s;
        bq.push_back({4'h0, 2'b00});
        do_aw(4'h0, a, 8'd0, 2'b01);
        do_w(1, 0, 1'b1);
        drain();
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0; bus.arlock = '0;
        bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
        bus.awsize = '0; bus.awburst = '0; bus.awlock = '0;
        bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wd[i] = '0;
            ws[i] = 4'hF;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", bus.arready, 1);
        chk("rst_awready", bus.awready, 1);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_bresp", bus.bresp, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        bq.push_back({4'h3, 2'b00});
        do_aw(4'h3, 32'h100, 8'd3, 2'b01);
        do_w(4, 3, 1'b1);
        drain();
        exp_r(32'h11, 4'h5, 0);
        exp_r(32'h22, 4'h5, 0);
        exp_r(32'h33, 4'h5, 0);
        exp_r(32'h44, 4'h5, 1);
        do_ar(4'h5, 32'h100, 8'd3, 2'b01);
        drain();

        rhold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wd[0] = 32'h55; wd[1] = 32'h66;
        do_aw(4'h8, 32'h500, 8'd3, 2'b01);
        do_w(2, 3, 1'b0);
        do_ar(4'h9, 32'h100, 8'd3, 2'b01);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rvalid", bus.rvalid, 0);
        chk("midrst_bvalid", bus.bvalid, 0);
        chk("midrst_wready", bus.wready, 0);
        chk("midrst_arready", bus.arready, 1);
        chk("midrst_awready", bus.awready, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        rhold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_r(32'h11, 4'hA, 0);
        exp_r(32'h22, 4'hA, 0);
        exp_r(32'h33, 4'hA, 0);
        exp_r(32'h44, 4'hA, 1);
        do_ar(4'hA, 32'h100, 8'd3, 2'b01);
        drain();

        wr1(32'h200, 32'hAABBCCDD, 4'hF);
        wr1(32'h200, 32'h11223344, 4'b0101);
        exp_r(32'hAA22CC44, 4'h1, 1);
        do_ar(4'h1, 32'h200, 8'd0, 2'b01);
        drain();

        for (int i = 0; i < 8; i++) begin
            wd[i] = 32'h7000 + i;
            ws[i] = 4'hF;
        end
        bq.push_back({4'h4, 2'b00});
        do_aw(4'h4, 32'h700, 8'd7, 2'b01);
        do_w(8, 7, 1'b1);
        drain();
        for (int i = 0; i < 8; i++) exp_r(32'h7000 + i, 4'hC, i == 7);
        tog = 1'b1;
        do_ar(4'hC, 32'h700, 8'd7, 2'b01);
        drain();
        tog = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        bus.wdata = 32'hFFFF_FFFF;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wready_before_aw", bus.wready, 0);
        end
        @(posedge clk);
        #1 bus.wvalid = 1'b0;

        wd[0] = 32'hA1; wd[1] = 32'hA2;
        bq.push_back({4'h1, 2'b10});
        do_aw(4'h1, 32'h600, 8'd1, 2'b01);
        do_w(2, 0, 1'b1);
        drain();
        exp_r(32'hA1, 4'h2, 0);
        exp_r(32'hA2, 4'h2, 1);
        do_ar(4'h2, 32'h600, 8'd1, 2'b01);
        drain();

        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
        bq.push_back({4'h2, 2'b00});
        do_aw(4'h2, 32'h300, 8'd3, 2'b00);
        do_w(4, 3, 1'b1);
        drain();
        exp_r(32'h4, 4'h3, 0);
        exp_r(32'h4, 4'h3, 1);
        do_ar(4'h3, 32'h300, 8'd1, 2'b00);
        drain();

        wr1(32'h400, 32'hDEAD0001, 4'hF);
        wd[0] = 32'hBEEF0002;
        ws[0] = 4'hF;
        exp_r(32'hDEAD0001, 4'h6, 1);
        bq.push_back({4'h7, 2'b00});
        fork
            do_ar(4'h6, 32'h400, 8'd0, 2'b01);
            begin
                do_aw(4'h7, 32'h400, 8'd0, 2'b01);
                do_w(1, 0, 1'b1);
            end
        join
        drain();
        exp_r(32'hBEEF0002, 4'h8, 1);
        do_ar(4'h8, 32'h400, 8'd0, 2'b01);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end
endmodule
